im2_vector_ctl: RTL

IM2_VECTOR_CTL -- requirements
Module: im2_vector_ctl

---
 rtl/im2_vector_ctl_if.sv | 30 +++
 rtl/im2_vector_ctl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/im2_vector_ctl_if.sv
// CPU-side bus bundle for the IM2 vector controller: bus snoop, request
// inputs, configuration and the vector/status outputs.
interface im2_vector_ctl_if;
   logic       m1;
   logic       mreq;
   logic       iorq;
   logic       rd;
   logic [7:0] d_in;
   logic [3:0] irq;
   logic [3:0] irq_mask;
   logic       im2_en;
   logic [4:0] vector_base;
   logic       n_int_req;
   logic [7:0] d_out;
   logic       d_oe;
   logic [3:0] pending;
   logic [3:0] in_service;

   // Bus/CPU side: drives strobes and requests, observes vector and status.
   modport master (
      output m1, mreq, iorq, rd, d_in, irq, irq_mask, im2_en, vector_base,
      input  n_int_req, d_out, d_oe, pending, in_service
   );

   // Controller side.
   modport slave (
      input  m1, mreq, iorq, rd, d_in, irq, irq_mask, im2_en, vector_base,
      output n_int_req, d_out, d_oe, pending, in_service
   );
endinterface

// File: rtl/im2_vector_ctl.sv
// Z80 mode-2 interrupt vector controller with four prioritised sources.
// Latches request pulses, arbitrates against the in-service chain, supplies
// the vector byte during the interrupt acknowledge cycle and snoops opcode
// fetches for RETI (ED 4D) to retire the highest-priority in-service source.
module im2_vector_ctl (
   input  logic            clk28,
   input  logic            rst,
   im2_vector_ctl_if.slave bus
);

   typedef enum logic {A_IDLE, A_ACK} ack_state_t;
   typedef enum logic {R_IDLE, R_ED}  reti_state_t;

   localparam logic [7:0] OP_ED    = 8'hED;
   localparam logic [7:0] OP_4D    = 8'h4D;
   localparam logic [7:0] BUS_IDLE = 8'hFF;

   ack_state_t  ack_state;
   reti_state_t reti_state;

   logic       inta, inta_prev, ack_start, ack_end;
   logic       fetch, fetch_prev, fetch_end, reti_hit;
   logic [7:0] fetch_byte;
   logic [3:0] pending_r, in_service_r, eligible;
   logic [3:0] pending_nxt, in_service_nxt;
   logic [1:0] idx;
   logic       spurious;
   logic       n_int_req_r, d_oe_r;
   logic [7:0] d_out_r;

   // Index of the lowest-numbered (highest-priority) set bit.
   function automatic logic [1:0] lowest_set(input logic [3:0] v);
      if (v[0]) return 2'd0;
      if (v[1]) return 2'd1;
      if (v[2]) return 2'd2;
      return 2'd3;
   endfunction

   // Byte placed on the bus during acknowledge; floats high when not driving
   // a real vector.
   function automatic logic [7:0] vector_byte(input logic en, input logic spur,
                                              input logic [4:0] base, input logic [1:0] id);
      if (!en || spur) return BUS_IDLE;
      return {base, id, 1'b0};
   endfunction

   assign inta      = bus.m1 & bus.iorq;
   assign ack_start = inta & ~inta_prev;
   assign ack_end   = ~inta & inta_prev & (ack_state == A_ACK);

   // mreq is low during acknowledge, so the RETI snoop never sees INTA cycles.
   assign fetch     = bus.m1 & bus.mreq & bus.rd;
   assign fetch_end = fetch_prev & ~fetch;
   assign reti_hit  = fetch_end & (reti_state == R_ED) & (fetch_byte == OP_4D);

   // A source may request only if nothing of equal or higher priority is in service.
   assign eligible[0] = pending_r[0] & ~bus.irq_mask[0] & ~in_service_r[0];
   assign eligible[1] = pending_r[1] & ~bus.irq_mask[1] & ~|in_service_r[1:0];
   assign eligible[2] = pending_r[2] & ~bus.irq_mask[2] & ~|in_service_r[2:0];
   assign eligible[3] = pending_r[3] & ~bus.irq_mask[3] & ~|in_service_r[3:0];

   // Next pending/in-service: retire on RETI, move acknowledged source to
   // service, then let a new pulse override any same-cycle clear.
   always_comb begin
      pending_nxt    = pending_r;
      in_service_nxt = in_service_r;
      if (reti_hit && |in_service_r)
         in_service_nxt[lowest_set(in_service_r)] = 1'b0;
      if (ack_end && !spurious) begin
         pending_nxt[idx]    = 1'b0;
         in_service_nxt[idx] = 1'b1;
      end
      pending_nxt = pending_nxt | bus.irq;
   end

   // Request/service bookkeeping and the registered INT request.
   always_ff @(posedge clk28) begin
      if (rst) begin
         pending_r    <= 4'b0000;
         in_service_r <= 4'b0000;
         n_int_req_r  <= 1'b1;
      end else begin
         pending_r    <= pending_nxt;
         in_service_r <= in_service_nxt;
         n_int_req_r  <= ~|eligible;
      end
   end

   // Acknowledge FSM: captures the winning source on INTA rise and drives the
   // vector until INTA falls.
   always_ff @(posedge clk28) begin
      if (rst) begin
         ack_state <= A_IDLE;
         inta_prev <= 1'b0;
         idx       <= 2'd0;
         spurious  <= 1'b0;
         d_oe_r    <= 1'b0;
         d_out_r   <= BUS_IDLE;
      end else begin
         inta_prev <= inta;
         case (ack_state)
            A_IDLE: begin
               d_oe_r  <= 1'b0;
               d_out_r <= BUS_IDLE;
               if (ack_start) begin
                  ack_state <= A_ACK;
                  idx       <= lowest_set(eligible);
                  spurious  <= ~|eligible;
                  d_oe_r    <= bus.im2_en;
                  d_out_r   <= vector_byte(bus.im2_en, ~|eligible, bus.vector_base,
                                           lowest_set(eligible));
               end
            end
            A_ACK: begin
               if (ack_end) begin
                  ack_state <= A_IDLE;
                  d_oe_r    <= 1'b0;
                  d_out_r   <= BUS_IDLE;
               end else begin
                  d_oe_r  <= bus.im2_en;
                  d_out_r <= vector_byte(bus.im2_en, spurious, bus.vector_base, idx);
               end
            end
            default: ack_state <= A_IDLE;
         endcase
      end
   end

   // Opcode snoop: keep the most recent byte seen during an active fetch.
   always_ff @(posedge clk28) begin
      if (fetch) fetch_byte <= bus.d_in;
   end

   // RETI FSM: advances once per completed opcode fetch.
   always_ff @(posedge clk28) begin
      if (rst) begin
         reti_state <= R_IDLE;
         fetch_prev <= 1'b0;
      end else begin
         fetch_prev <= fetch;
         if (fetch_end) begin
            case (reti_state)
               R_IDLE:  reti_state <= (fetch_byte == OP_ED) ? R_ED : R_IDLE;
               R_ED:    reti_state <= (fetch_byte == OP_ED) ? R_ED : R_IDLE;
               default: reti_state <= R_IDLE;
            endcase
         end
      end
   end

   assign bus.n_int_req  = n_int_req_r;
   assign bus.d_oe       = d_oe_r;
   assign bus.d_out      = d_out_r;
   assign bus.pending    = pending_r;
   assign bus.in_service = in_service_r;

endmodule
